// File: rtl/fifo_axis_packer_pkg.sv
// fifo_axis_packer_pkg: shared types and helpers for the FIFO-to-AXIS byte packer.
package fifo_axis_packer_pkg;
  typedef enum logic {S_FILL, S_SEND} state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int AXIS_DW = 32;
  function automatic logic [3:0] keep_of(input logic [2:0] n);
    return 4'((5'd1 << n) - 5'd1);
  endfunction
  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    return {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
  endfunction
endpackage

// File: rtl/fifo_axis_packer.sv
// fifo_axis_packer: drains a byte FIFO, packs bytes little-endian into 32-bit AXI4-Stream words
// with TLAST on packet length, flush or idle timeout; partial words carry TKEEP.
module fifo_axis_packer
  import fifo_axis_packer_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH = 4,
  parameter int PKT_WORDS       = 16,
  parameter int FLUSH_TIMEOUT   = 255
) (
  input  logic                      rdclk,
  input  logic                      reset_n,
  output logic                      fifo_rden,
  input  logic [7:0]                fifo_dout,
  input  logic                      fifo_empty,
  input  logic [FIFO_ADDR_WIDTH:0]  fifo_count,
  input  logic                      flush,
  output logic [AXIS_DW-1:0]        m_axis_tdata,
  output logic [BYTES_PER_WORD-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy
);
  localparam int WCW = PKT_WORDS > 1 ? $clog2(PKT_WORDS) : 1;
  localparam int ICW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int CW  = FIFO_ADDR_WIDTH + 1;
  state_e                    state_q, state_d;
  logic [2:0]                byte_cnt_q, byte_cnt_d;
  logic [WCW-1:0]            word_cnt_q, word_cnt_d;
  logic [ICW-1:0]            idle_cnt_q, idle_cnt_d;
  logic                      rd_pend_q, rd_pend_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [AXIS_DW-1:0]        tdata_q, tdata_d;
  logic [BYTES_PER_WORD-1:0] tkeep_q, tkeep_d;
  logic                      tlast_q, tlast_d;
  logic                      tvalid_q, tvalid_d;
  logic fill, cap, have, fl_req, full, idle, tmo, part;
  assign fill   = state_q == S_FILL;
  assign cap    = fill & rd_pend_q;
  assign have   = byte_cnt_q != 3'd0 | rd_pend_q;
  assign fl_req = fill & (flush | flush_pend_q) & have;
  assign full   = cap & byte_cnt_q == 3'd3;
  assign idle   = fill & byte_cnt_q != 3'd0 & ~rd_pend_q & fifo_empty;
  assign tmo    = idle & idle_cnt_q == ICW'(FLUSH_TIMEOUT - 1);
  // A flush that arrives while a read is being issued waits one cycle so that byte is not lost
  assign part   = (fl_req & ~rd_pend_q & ~fifo_rden) | tmo;
  assign fifo_rden = reset_n & fill & ~fifo_empty & ~(flush_pend_q & have)
                   & (byte_cnt_q + 3'(rd_pend_q) < 3'd4);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy = byte_cnt_q != 3'd0 | rd_pend_q | tvalid_q;
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    tdata_d      = tdata_q;
    tkeep_d      = tkeep_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;
    rd_pend_d    = fifo_rden;
    idle_cnt_d   = idle ? idle_cnt_q + ICW'(1) : '0;
    flush_pend_d = fill ? fl_req : flush_pend_q | flush;
    if (cap) begin
      tdata_d[{byte_cnt_q[1:0], 3'b000} +: 8] = fifo_dout;
      byte_cnt_d = byte_cnt_q + 3'd1;
    end
    if (full) begin
      tkeep_d      = '1;
      tlast_d      = word_cnt_q == WCW'(PKT_WORDS - 1) | fl_req;
      tvalid_d     = 1'b1;
      state_d      = S_SEND;
      flush_pend_d = 1'b0;
    end else if (part) begin
      tkeep_d      = keep_of(byte_cnt_q);
      tdata_d      = tdata_q & lane_mask(keep_of(byte_cnt_q));
      tlast_d      = 1'b1;
      tvalid_d     = 1'b1;
      state_d      = S_SEND;
      flush_pend_d = 1'b0;
      idle_cnt_d   = '0;
    end
    if (tvalid_q & m_axis_tready) begin
      tvalid_d   = 1'b0;
      tlast_d    = 1'b0;
      byte_cnt_d = 3'd0;
      state_d    = S_FILL;
      word_cnt_d = tlast_q ? '0 : word_cnt_q + WCW'(1);
    end
  end
  always_ff @(posedge rdclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FILL;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      rd_pend_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      tdata_q      <= '0;
      tkeep_q      <= '0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      rd_pend_q    <= rd_pend_d;
      flush_pend_q <= flush_pend_d;
      tdata_q      <= tdata_d;
      tkeep_q      <= tkeep_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
    end
  end
  // fifo_count is status only; it is sanity-checked against the FIFO depth and empty flag
  always_ff @(posedge rdclk) begin
    if (reset_n) begin
      assert (fifo_count <= CW'(1 << FIFO_ADDR_WIDTH));
      assert (!fifo_empty || fifo_count == '0);
    end
  end
endmodule

// File: tb/tb_fifo_axis_packer.sv
// tb_fifo_axis_packer: randomized bench for fifo_axis_packer against a byte-stream packet model.
module tb_fifo_axis_packer;
  localparam int AW = 4;
  localparam int PW = 4;
  localparam int TO = 20;
  localparam int CW = AW + 1;
  typedef struct packed {logic [31:0] d; logic [3:0] k; logic l;} word_t;
  logic clk = 0, reset_n = 1, fifo_rden, fifo_empty = 1, flush = 0, tready = 0;
  logic tvalid, tlast, busy, take = 0, stall = 0;
  logic [7:0] fifo_dout = 0;
  logic [CW-1:0] fifo_count = 0;
  logic [31:0] tdata;
  logic [3:0] tkeep;
  logic [7:0] fq[$];
  logic [7:0] pend[$];
  word_t exp_q[$];
  word_t w, prev;
  int wic = 0, total = 0, bad = 0, tr_mode = 1;
  always #5 clk = ~clk;
  fifo_axis_packer #(.FIFO_ADDR_WIDTH(AW), .PKT_WORDS(PW), .FLUSH_TIMEOUT(TO)) dut (
    .rdclk(clk), .reset_n(reset_n), .fifo_rden(fifo_rden), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_count(fifo_count), .flush(flush),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic emit_pend(input logic last);
    word_t e;
    e = '0;
    foreach (pend[i]) begin
      e.d[8*i +: 8] = pend[i];
      e.k[i] = 1'b1;
    end
    e.l = last;
    exp_q.push_back(e);
    wic = last ? 0 : wic + 1;
    pend.delete();
  endtask
  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    pend.push_back(b);
    if (pend.size() == 4) emit_pend(wic == PW - 1);
  endtask
  task automatic model_flush();
    if (pend.size() != 0) emit_pend(1'b1);
  endtask
  task automatic pulse_flush();
    @(negedge clk) flush = 1;
    @(negedge clk) flush = 0;
  endtask
  task automatic wait_empty();
    int n = 0;
    while (fq.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("fifo_drain", fq.size(), 0);
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin @(negedge clk); n++; end
    chk("out_drain", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask
  // FIFO read port: data appears the cycle after an accepted read
  always @(negedge clk) begin
    if (take && fq.size() != 0) fifo_dout = fq.pop_front();
    fifo_empty = fq.size() == 0;
    fifo_count = CW'(fq.size());
    #1;
    take = fifo_rden && !fifo_empty;
    if (fifo_empty) chk("rden_empty", fifo_rden, 0);
  end
  always @(negedge clk) begin
    tready = tr_mode == 1 ? 1'b1 : tr_mode == 2 ? 1'b0 : ($urandom % 4 != 0);
    if (stall) begin
      chk("hold_valid", tvalid, 1);
      chk("hold_word", {tdata, tkeep, tlast}, prev);
    end
    if (tvalid && tready) begin
      if (exp_q.size() == 0) chk("extra_word", 1, 0);
      else begin
        w = exp_q.pop_front();
        chk("tdata", tdata, w.d);
        chk("tkeep", tkeep, w.k);
        chk("tlast", tlast, w.l);
      end
    end
    stall = tvalid && !tready;
    prev = {tdata, tkeep, tlast};
  end
  initial begin
    int n;
    #1 reset_n = 0;
    push(8'h01);
    repeat (3) @(negedge clk);
    #2;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rden", fifo_rden, 0);
    @(posedge clk) #2 reset_n = 1;
    for (int b = 2; b <= 8; b++) push(8'(b));
    wait_drain();
    @(posedge clk) #2;
    for (int b = 0; b < 16; b++) push(8'(8'h10 + b));
    wait_drain();
    @(posedge clk) #2;
    push(8'hAA); push(8'hBB); push(8'hCC);
    wait_empty();
    repeat (3) @(negedge clk);
    model_flush();
    pulse_flush();
    wait_drain();
    pulse_flush();
    repeat (3) @(negedge clk);
    chk("idle_flush_tvalid", tvalid, 0);
    chk("idle_flush_busy", busy, 0);
    // push -> read accept -> capture -> TO idle cycles -> tvalid
    @(posedge clk) #2;
    push(8'h5A);
    model_flush();
    n = 0;
    while (!tvalid && n < 200) begin @(negedge clk); n++; end
    chk("tmo_cycles", n, TO + 3);
    wait_drain();
    tr_mode = 2;
    @(posedge clk) #2;
    for (int b = 0; b < 8; b++) push(8'(8'h80 + b));
    repeat (20) @(negedge clk);
    chk("stall_count", fifo_count, 4);
    chk("stall_valid", tvalid, 1);
    tr_mode = 1;
    wait_drain();
    @(posedge clk) #2;
    push(8'hE1); push(8'hE2);
    wait_empty();
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_tvalid", tvalid, 0);
    #3 reset_n = 0;
    #1;
    chk("async_tvalid", tvalid, 0);
    chk("async_busy", busy, 0);
    fq.delete(); pend.delete(); exp_q.delete(); wic = 0;
    @(posedge clk) #2 reset_n = 1;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    wait_drain();
    tr_mode = 0;
    for (int p = 0; p < 40; p++) begin
      int g = 0, a;
      while (fq.size() > 8 && g < 500) begin @(negedge clk); g++; end
      @(posedge clk) #2;
      n = $urandom_range(1, 8);
      repeat (n) push(8'($urandom));
      a = $urandom % 4;
      if (a == 0) begin
        wait_empty();
        repeat (3) @(negedge clk);
        model_flush();
        pulse_flush();
      end else if (a == 1) begin
        wait_empty();
        model_flush();
        repeat (TO + 8) @(negedge clk);
      end
    end
    wait_empty();
    repeat (3) @(negedge clk);
    model_flush();
    pulse_flush();
    wait_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
